mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter sharing the single-ported unified instruction/data memory of the pipelined RV32I core between the fetch stage (IF) and the memory stage (DM). It grants one requester at a time, latches the winner's address and write data onto the memory port, drives the select of the 2:1 port multiplexer, holds the grant until the memory handshakes, and returns the read data and an acknowledge to the winner. The hazard unit stalls the pipeline from the acknowledge signals.

## Interface

Parameters:
- TIMEOUT, 255: maximum cycles a granted access waits for mem_ready before it is aborted; legal range 1–255.

Ports:
- clk  in  1  core clock; everything updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  32  fetch address; held stable until if_ack.
- if_ack  out  1  one-cycle completion pulse to fetch.
- if_rdata  out  32  instruction word; valid only while if_ack=1.
- dm_req  in  1  load/store request; held high until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_be  in  4  store byte enables.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_ack  out  1  one-cycle completion pulse to the memory stage.
- dm_rdata  out  32  load data; valid only while dm_ack=1.
- mem_req  out  1  memory access active, registered.
- mem_we  out  1  registered; 0 for fetches.
- mem_be  out  4  registered; 4'b0000 for fetches.
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered; 0 for fetches.
- mem_rdata  in  32  memory read data.
- mem_ready  in  1  memory completes the current access this cycle.
- sel  out  1  port-mux select, registered; 0 = IF, 1 = DM.
- err  out  1  sticky timeout flag.

## Operation

- States: IDLE, BUSY_IF, BUSY_DM. Wait counter wcnt is 8 bits wide.
- IDLE:
  - dm_req=1 → BUSY_DM. The data stage wins ties because it holds the older instruction.
  - Otherwise if_req=1 → BUSY_IF.
  - Otherwise stay in IDLE.
- On every grant edge:
  - Latch the winner's addr/we/be/wdata into the mem_* registers.
  - Set mem_req=1 and sel to the winner.
  - Clear wcnt.
  - A fetch grant forces mem_we=0, mem_be=0, mem_wdata=0.
- BUSY_x with mem_ready=1 (completion cycle):
  - x_ack=1 combinationally in the same cycle.
  - x_rdata = mem_rdata.
  - Next state: re-arbitrate, excluding requester x, whose req this cycle belongs to the completed access.
  - If the other requester's req=1, go to BUSY_other and latch its fields back-to-back, with mem_req staying 1.
  - Otherwise go to IDLE and clear mem_req, sel, we, be, addr and wdata.
- The exclusion above makes both requesters alternate when both request continuously. Neither can starve.
- BUSY_x with mem_ready=0: wcnt increments and the state holds.
  - When wcnt = TIMEOUT-1 and mem_ready=0, the access is aborted.
  - On abort, x_ack=1 with x_rdata=0, err is set, and the next state follows the same rule as completion.
- Outside an ack cycle, the ack outputs are 0 and the rdata outputs are 0.
- Requests that arrive while the other requester is busy wait. They are not queued beyond the single req line.
- err stays set until reset and does not block further arbitration.

## Timing

- Reset (rst_n=0 at an edge) forces:
  - state=IDLE, wcnt=0, err=0.
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, sel=0.
  - if_ack=0, dm_ack=0, rdata outputs 0.
- Reset during BUSY_x abandons the access. No ack is issued and mem_req is low in the cycle after the reset edge.
- Latency from IDLE: a request seen at edge N gives mem_req=1 in cycle N+1. With mem_ready=1 in that cycle, ack arrives in cycle N+1, so the minimum is one cycle of wait after the request edge.
- Back-to-back accesses: the second access starts in the cycle after the first ack, with no idle bubble.
- Timeout: a zero-ready access acks exactly TIMEOUT cycles after mem_req rises. err is visible from the following cycle.
- mem_ready is ignored in IDLE.

## Test plan

- Reset then single fetch:
  - Stimulus: if_addr=0x0000_0010, mem_ready=1, mem_rdata=0x0000_0013.
  - Required: mem_req, sel=0 and mem_addr=0x10 one cycle after the request; if_ack=1 and if_rdata=0x13 in that same cycle; IDLE next.
- Simultaneous requests from IDLE:
  - Stimulus: IF plus a store (dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_be=4'hF).
  - Required: DM granted first with sel=1, mem_we=1; after dm_ack, IF is granted in the next cycle with sel=0, mem_we=0 and no bubble.
- Both requesting continuously, mem_ready=1 every cycle:
  - Required: grants alternate DM, IF, DM, IF; each requester receives one ack every 2 cycles.
- Load with mem_ready delayed 3 cycles:
  - Required: mem_addr and sel held stable for 4 cycles; dm_ack is a single pulse carrying mem_rdata; if_req arriving mid-access waits.
- Timeout:
  - Stimulus: TIMEOUT=4, mem_ready held 0.
  - Required: ack in the 4th cycle of the access with rdata=0, err=1 afterward, and the next request still served normally.
- Reset mid-access:
  - Stimulus: rst_n=0 during BUSY_DM.
  - Required: no dm_ack; all outputs at their reset values one cycle after the edge.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data-stage and memory-port signals shared by the
// unified-memory arbiter. slave = arbiter view, master = surrounding pipeline/memory.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        sel;
    logic        err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  mem_rdata, mem_ready,
        output if_ack, if_rdata, dm_ack, dm_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata, sel, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output mem_rdata, mem_ready,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, sel, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch (IF) and the memory stage (DM);
// DM wins ties, the just-served requester is skipped so both alternate.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] wcnt;
    logic       timeout_hit;
    logic       abort;
    logic       grant_if;
    logic       grant_dm;

    always_comb begin
        state_nx      = state;
        timeout_hit   = (wcnt == WCNT_LAST) && !bus.mem_ready;
        abort         = 1'b0;
        bus.if_ack    = 1'b0;
        bus.if_rdata  = 32'h0;
        bus.dm_ack    = 1'b0;
        bus.dm_rdata  = 32'h0;
        case (state)
            IDLE: begin
                if (bus.dm_req)      state_nx = BUSY_DM;
                else if (bus.if_req) state_nx = BUSY_IF;
            end
            // Completion or abort ends the access; the finished requester is excluded
            BUSY_IF: begin
                if (rst_n && (bus.mem_ready || timeout_hit)) begin
                    abort        = timeout_hit;
                    bus.if_ack   = 1'b1;
                    bus.if_rdata = timeout_hit ? 32'h0 : bus.mem_rdata;
                    state_nx     = bus.dm_req ? BUSY_DM : IDLE;
                end
            end
            BUSY_DM: begin
                if (rst_n && (bus.mem_ready || timeout_hit)) begin
                    abort        = timeout_hit;
                    bus.dm_ack   = 1'b1;
                    bus.dm_rdata = timeout_hit ? 32'h0 : bus.mem_rdata;
                    state_nx     = bus.if_req ? BUSY_IF : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A state change into BUSY_x is always a fresh grant (BUSY_x never re-grants itself)
    assign grant_dm = (state_nx == BUSY_DM) && (state != BUSY_DM);
    assign grant_if = (state_nx == BUSY_IF) && (state != BUSY_IF);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            wcnt          <= 8'd0;
            bus.err       <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'b0000;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
            bus.sel       <= 1'b0;
        end else begin
            state <= state_nx;
            if (abort) bus.err <= 1'b1;
            if (grant_dm) begin
                bus.mem_req   <= 1'b1;
                bus.sel       <= 1'b1;
                bus.mem_we    <= bus.dm_we;
                bus.mem_be    <= bus.dm_be;
                bus.mem_addr  <= bus.dm_addr;
                bus.mem_wdata <= bus.dm_wdata;
                wcnt          <= 8'd0;
            end else if (grant_if) begin
                bus.mem_req   <= 1'b1;
                bus.sel       <= 1'b0;
                bus.mem_we    <= 1'b0;
                bus.mem_be    <= 4'b0000;
                bus.mem_addr  <= bus.if_addr;
                bus.mem_wdata <= 32'h0;
                wcnt          <= 8'd0;
            end else if (state_nx == IDLE) begin
                bus.mem_req   <= 1'b0;
                bus.sel       <= 1'b0;
                bus.mem_we    <= 1'b0;
                bus.mem_be    <= 4'b0000;
                bus.mem_addr  <= 32'h0;
                bus.mem_wdata <= 32'h0;
                wcnt          <= 8'd0;
            end else begin
                wcnt <= wcnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter built with TIMEOUT=4; inputs change
// 2 time units after the rising edge, outputs are sampled 4 units later.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n         = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_be     = 4'h0;
        bus.dm_addr   = 32'h0;
        bus.dm_wdata  = 32'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ready = 1'b0;
        next_cycle();
        next_cycle();
        settle();
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_sel",     32'(bus.sel),     32'h0);
        chk("rst_err",     32'(bus.err),     32'h0);
        chk("rst_addr",    bus.mem_addr,     32'h0);
        chk("rst_acks",    32'({bus.if_ack, bus.dm_ack}), 32'h0);

        // Single fetch; mem_ready is ignored while idle
        next_cycle();
        rst_n = 1'b1;
        bus.if_req = 1'b1;  bus.if_addr = 32'h10;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h13;
        settle();
        chk("idle_no_ack", 32'(bus.if_ack), 32'h0);
        next_cycle();
        settle();
        chk("f_mem_req", 32'(bus.mem_req), 32'h1);
        chk("f_sel",     32'(bus.sel),     32'h0);
        chk("f_addr",    bus.mem_addr,     32'h10);
        chk("f_ack",     32'(bus.if_ack),  32'h1);
        chk("f_rdata",   bus.if_rdata,     32'h13);
        next_cycle();
        bus.if_req = 1'b0;
        settle();
        chk("f_idle_req", 32'(bus.mem_req), 32'h0);
        chk("f_idle_ack", 32'(bus.if_ack),  32'h0);
        chk("f_idle_rd",  bus.if_rdata,     32'h0);

        // Simultaneous IF + store: DM first, IF right after
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_be = 4'hF;
        bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEADBEEF;
        bus.mem_rdata = 32'h00A0_0093;
        next_cycle();
        settle();
        chk("s_sel",    32'(bus.sel),    32'h1);
        chk("s_we",     32'(bus.mem_we), 32'h1);
        chk("s_be",     32'(bus.mem_be), 32'hF);
        chk("s_addr",   bus.mem_addr,    32'h100);
        chk("s_wdata",  bus.mem_wdata,   32'hDEADBEEF);
        chk("s_dm_ack", 32'(bus.dm_ack), 32'h1);
        chk("s_if_ack", 32'(bus.if_ack), 32'h0);
        next_cycle();
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = 4'h0;
        settle();
        chk("s2_req",    32'(bus.mem_req), 32'h1);
        chk("s2_sel",    32'(bus.sel),     32'h0);
        chk("s2_we",     32'(bus.mem_we),  32'h0);
        chk("s2_be",     32'(bus.mem_be),  32'h0);
        chk("s2_wdata",  bus.mem_wdata,    32'h0);
        chk("s2_addr",   bus.mem_addr,     32'h20);
        chk("s2_if_ack", 32'(bus.if_ack),  32'h1);
        chk("s2_rdata",  bus.if_rdata,     32'h00A0_0093);
        next_cycle();
        bus.if_req = 1'b0;
        settle();
        chk("s_idle", 32'(bus.mem_req), 32'h0);

        // Both requesting continuously: DM, IF, DM, IF ...
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h200;
        bus.mem_rdata = 32'h5A5A_0001;
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            if (k == 6) bus.if_req = 1'b0;
            settle();
            chk($sformatf("alt%0d_sel", k),    32'(bus.sel),    32'((k % 2) == 0));
            chk($sformatf("alt%0d_dm_ack", k), 32'(bus.dm_ack), 32'((k % 2) == 0));
            chk($sformatf("alt%0d_if_ack", k), 32'(bus.if_ack), 32'((k % 2) == 1));
            chk($sformatf("alt%0d_addr", k),   bus.mem_addr,    ((k % 2) == 0) ? 32'h200 : 32'h40);
        end
        next_cycle();
        bus.dm_req = 1'b0;
        settle();
        chk("alt_idle", 32'(bus.mem_req), 32'h0);

        // Load with mem_ready delayed 3 cycles; a fetch arrives mid-access
        bus.dm_req = 1'b1; bus.dm_addr = 32'h300; bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h1234_5678;
        for (int a = 0; a < 3; a++) begin
            next_cycle();
            if (a == 1) begin
                bus.if_req = 1'b1; bus.if_addr = 32'h50;
            end
            settle();
            chk($sformatf("ld%0d_sel", a),    32'(bus.sel),    32'h1);
            chk($sformatf("ld%0d_addr", a),   bus.mem_addr,    32'h300);
            chk($sformatf("ld%0d_dm_ack", a), 32'(bus.dm_ack), 32'h0);
            chk($sformatf("ld%0d_if_ack", a), 32'(bus.if_ack), 32'h0);
        end
        next_cycle();
        bus.mem_ready = 1'b1;
        settle();
        chk("ld3_addr",   bus.mem_addr,    32'h300);
        chk("ld3_dm_ack", 32'(bus.dm_ack), 32'h1);
        chk("ld3_rdata",  bus.dm_rdata,    32'h1234_5678);
        next_cycle();
        bus.dm_req = 1'b0;
        settle();
        chk("ld_if_ack", 32'(bus.if_ack), 32'h1);
        chk("ld_dm_ack", 32'(bus.dm_ack), 32'h0);
        chk("ld_if_sel", 32'(bus.sel),    32'h0);
        chk("ld_if_adr", bus.mem_addr,    32'h50);
        chk("ld_err",    32'(bus.err),    32'h0);
        next_cycle();
        bus.if_req = 1'b0;
        settle();
        chk("ld_idle", 32'(bus.mem_req), 32'h0);

        // Timeout on a fetch with mem_ready held low
        bus.if_req = 1'b1; bus.if_addr = 32'h60;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
        for (int a = 0; a < 3; a++) begin
            next_cycle();
            settle();
            chk($sformatf("to%0d_ack", a), 32'(bus.if_ack), 32'h0);
        end
        next_cycle();
        settle();
        chk("to3_ack",   32'(bus.if_ack), 32'h1);
        chk("to3_rdata", bus.if_rdata,    32'h0);
        chk("to3_err",   32'(bus.err),    32'h0);
        next_cycle();
        bus.if_req = 1'b0;
        settle();
        chk("to_err",  32'(bus.err),     32'h1);
        chk("to_idle", 32'(bus.mem_req), 32'h0);
        bus.dm_req = 1'b1; bus.dm_addr = 32'h400;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_CAFE;
        next_cycle();
        settle();
        chk("post_ack",   32'(bus.dm_ack), 32'h1);
        chk("post_rdata", bus.dm_rdata,    32'h0000_CAFE);
        chk("post_err",   32'(bus.err),    32'h1);
        next_cycle();
        bus.dm_req = 1'b0;

        // Reset in the middle of a data access
        bus.dm_req = 1'b1; bus.dm_addr = 32'h500; bus.mem_ready = 1'b0;
        next_cycle();
        settle();
        chk("rm_busy", 32'(bus.mem_req), 32'h1);
        next_cycle();
        rst_n = 1'b0;
        settle();
        chk("rm_no_ack", 32'(bus.dm_ack), 32'h0);
        next_cycle();
        settle();
        chk("rm_req",  32'(bus.mem_req), 32'h0);
        chk("rm_sel",  32'(bus.sel),     32'h0);
        chk("rm_addr", bus.mem_addr,     32'h0);
        chk("rm_err",  32'(bus.err),     32'h0);
        chk("rm_ack",  32'(bus.dm_ack),  32'h0);
        rst_n = 1'b1;
        bus.dm_req = 1'b0;
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
